// File: rtl/sram_link_initiator.sv
// Host-side initiator for the byte-serial SRAM link: turns one word request into a
// command byte plus data bytes and assembles the word-level response.
module sram_link_initiator #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TO_W           = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [4:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        link_tx_valid,
   input  logic        link_tx_ready,
   output logic [7:0]  link_tx_data,
   input  logic        link_rx_valid,
   output logic        link_rx_ready,
   input  logic [7:0]  link_rx_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_write,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   output logic        drop_pulse
);

   // Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1;
   // a valid source holds its data stable until that edge.
   typedef enum logic [2:0] {IDLE, CMD, WR_DATA, RD_COLLECT, RESP} state_t;

   state_t            state, state_d;
   logic [1:0]        cnt;
   logic [TO_W-1:0]   to_cnt;
   logic              wr_q;
   logic [4:0]        addr_q;
   logic [31:0]       wdata_q;
   logic              rx_fire;
   logic              to_hit;
   logic              last_byte;

   assign req_ready     = (state == IDLE);
   assign link_tx_valid = (state == CMD) || (state == WR_DATA);
   assign link_rx_ready = 1'b1;
   assign rsp_valid     = (state == RESP);

   assign rx_fire   = (state == RD_COLLECT) && link_rx_valid;
   assign last_byte = (cnt == 2'd3);
   // Fires on the cycle whose increment would bring the counter to the limit.
   assign to_hit    = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:       if (req_valid) state_d = CMD;
         CMD:        if (link_tx_ready) state_d = wr_q ? WR_DATA : RD_COLLECT;
         WR_DATA:    if (link_tx_ready && last_byte) state_d = RESP;
         RD_COLLECT: if ((rx_fire && last_byte) || to_hit) state_d = RESP;
         RESP:       if (rsp_ready) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= 2'd0;
         to_cnt       <= '0;
         wr_q         <= 1'b0;
         addr_q       <= 5'd0;
         wdata_q      <= 32'd0;
         link_tx_data <= 8'd0;
         rsp_write    <= 1'b0;
         rsp_err      <= 1'b0;
         rsp_rdata    <= 32'd0;
         drop_pulse   <= 1'b0;
      end else begin
         drop_pulse <= link_rx_valid && (state != RD_COLLECT);
         case (state)
            IDLE: begin
               if (req_valid) begin
                  wr_q         <= req_write;
                  addr_q       <= req_addr;
                  wdata_q      <= req_wdata;
                  link_tx_data <= {2'b00, ~req_write, req_addr};
               end
            end
            CMD: begin
               if (link_tx_ready) begin
                  cnt <= 2'd0;
                  if (wr_q) begin
                     link_tx_data <= wdata_q[31:24];
                     wdata_q      <= {wdata_q[23:0], 8'h00};
                  end else begin
                     link_tx_data <= 8'd0;
                     to_cnt       <= '0;
                     rsp_rdata    <= 32'd0;
                  end
               end
            end
            WR_DATA: begin
               if (link_tx_ready) begin
                  cnt <= cnt + 2'd1;
                  if (last_byte) begin
                     link_tx_data <= 8'd0;
                     rsp_write    <= 1'b1;
                     rsp_err      <= 1'b0;
                     rsp_rdata    <= 32'd0;
                  end else begin
                     link_tx_data <= wdata_q[31:24];
                     wdata_q      <= {wdata_q[23:0], 8'h00};
                  end
               end
            end
            RD_COLLECT: begin
               to_cnt <= to_cnt + 1'b1;
               if (rx_fire) begin
                  cnt <= cnt + 2'd1;
                  case (cnt)
                     2'd0:    rsp_rdata[7:0]   <= link_rx_data;
                     2'd1:    rsp_rdata[15:8]  <= link_rx_data;
                     2'd2:    rsp_rdata[23:16] <= link_rx_data;
                     default: rsp_rdata[31:24] <= link_rx_data;
                  endcase
               end
               // A 4th byte landing on the timeout cycle still completes cleanly.
               if (state_d == RESP) begin
                  rsp_write <= 1'b0;
                  rsp_err   <= !(rx_fire && last_byte);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
